// File: rtl/decoder_scan_pkg.sv
// Shared types and constants for the 2-to-4 decoder scan controller.
package decoder_scan_pkg;
  localparam int CODE_W = 2;
  localparam logic [CODE_W-1:0] CODE_LAST = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    BLANK = 2'd2
  } state_e;
endpackage

// File: rtl/decoder_dwell_cnt.sv
// Dwell down-counter: load has priority, decrement saturates at zero.
module decoder_dwell_cnt #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [DWELL_W-1:0] load_val_i,
  input  logic               dec_i,
  output logic               zero_o
);
  logic [DWELL_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/decoder_scan_ctrl.sv
// Scans a 2-to-4 decoder through codes 00..11 with a blank cycle between codes.
// Optional one-shot mode (oneshot/done ports) enabled by DECODER_SCAN_ONESHOT_EN.
module decoder_scan_ctrl
  import decoder_scan_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [DWELL_W-1:0] dwell,
  output logic               a,
  output logic               b,
  output logic               c,
  output logic               busy
`ifdef DECODER_SCAN_ONESHOT_EN
  ,
  input  logic               oneshot,
  output logic               done
`endif
);
  state_e              state_q;
  logic [CODE_W-1:0]   code_q;
  logic                c_q;
  logic                busy_q;
  logic                cnt_load;
  logic [DWELL_W-1:0]  cnt_val;
  logic                cnt_dec;
  logic                cnt_zero;
`ifdef DECODER_SCAN_ONESHOT_EN
  logic                oneshot_q;
  logic                done_q;
`endif

  // Stop reloads zero so the counter is cleared on the way back to IDLE.
  assign cnt_load = ((state_q == IDLE) && start && !stop) ||
                    ((state_q != IDLE) && stop) ||
                    (state_q == BLANK);
  assign cnt_val  = stop ? '0 : dwell;
  assign cnt_dec  = (state_q == RUN) && !stop;

  decoder_dwell_cnt #(.DWELL_W(DWELL_W)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      code_q    <= '0;
      c_q       <= 1'b0;
      busy_q    <= 1'b0;
`ifdef DECODER_SCAN_ONESHOT_EN
      oneshot_q <= 1'b0;
      done_q    <= 1'b0;
`endif
    end else begin
`ifdef DECODER_SCAN_ONESHOT_EN
      done_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (start && !stop) begin
            state_q   <= RUN;
            code_q    <= '0;
            c_q       <= 1'b1;
            busy_q    <= 1'b1;
`ifdef DECODER_SCAN_ONESHOT_EN
            oneshot_q <= oneshot;
`endif
          end
        end
        RUN: begin
          if (stop) begin
            state_q <= IDLE;
            code_q  <= '0;
            c_q     <= 1'b0;
            busy_q  <= 1'b0;
          end else if (cnt_zero) begin
`ifdef DECODER_SCAN_ONESHOT_EN
            if (oneshot_q && (code_q == CODE_LAST)) begin
              state_q <= IDLE;
              code_q  <= '0;
              c_q     <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else
`endif
            begin
              // Next code is presented during the blank cycle (break-before-make).
              state_q <= BLANK;
              code_q  <= code_q + 1'b1;
              c_q     <= 1'b0;
            end
          end
        end
        BLANK: begin
          if (stop) begin
            state_q <= IDLE;
            code_q  <= '0;
            c_q     <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            state_q <= RUN;
            c_q     <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          code_q  <= '0;
          c_q     <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign a    = code_q[1];
  assign b    = code_q[0];
  assign c    = c_q;
  assign busy = busy_q;
`ifdef DECODER_SCAN_ONESHOT_EN
  assign done = done_q;
`endif
endmodule

// File: doc/decoder_scan_ctrl.md
DECODER_SCAN_CTRL -- requirements
Module: decoder_scan_ctrl

Interface
REQ-001 SHALL have parameter: DWELL_W, default 8, width of the dwell count.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  reset; one clock, reset asynchronous and active-high.
REQ-004 SHALL have port: start  input  1  begin scanning when idle.
REQ-005 SHALL have port: stop  input  1  abort scanning.
REQ-006 SHALL have port: dwell  input  DWELL_W  extra cycles each code is held; held time is dwell+1 cycles.
REQ-007 SHALL have port: a  output  1  decoder select MSB.
REQ-008 SHALL have port: b  output  1  decoder select LSB.
REQ-009 SHALL have port: c  output  1  decoder enable, active-high.
REQ-010 SHALL have port: busy  output  1  high whenever state is not IDLE.

Function
REQ-011 SHALL register all outputs; no combinational input-to-output path.
REQ-012 SHALL implement FSM states IDLE, RUN, BLANK.
REQ-013 IDLE: a=b=c=0; start=1 and stop=0 -> RUN next cycle, code {a,b}=00, counter loaded with dwell.
REQ-014 SHALL assert c in the cycle after start is sampled (1-cycle latency).
REQ-015 RUN: c=1, {a,b}=current code; counter decrements by 1 each cycle.
REQ-016 RUN with counter=0 -> BLANK; {a,b} advances by 1 and wraps 11->00.
REQ-017 BLANK: exactly one cycle; c=0, {a,b} already shows the new code; break-before-make.
REQ-018 BLANK -> RUN; counter reloaded from dwell sampled in the BLANK cycle.
REQ-019 dwell SHALL be sampled only at load and reload; mid-dwell changes SHALL have no effect on the current code.
REQ-020 dwell=0 SHALL hold each code 1 cycle, giving a period of 2 cycles per code.
REQ-021 stop=1 in RUN or BLANK -> IDLE next cycle, with a=b=c=0 and counter=0.
REQ-022 start=1 and stop=1 together SHALL resolve to stop; the block SHALL remain in or enter IDLE.
REQ-023 start while RUN or BLANK SHALL be ignored and SHALL NOT restart the code sequence.
REQ-024 Counter SHALL NOT underflow; the decrement occurs only when the counter is non-zero.

Reset
REQ-025 rst=1 SHALL force IDLE asynchronously, with a=b=c=0, busy=0, counter=0 and code=00 (done=0 when the macro is defined).
REQ-026 Reset asserted mid-scan SHALL drop c within the same cycle, without waiting for a clock edge.
REQ-027 Leaving reset SHALL require a fresh start pulse; no autonomous scanning.

Configuration
REQ-028 Macro DECODER_SCAN_ONESHOT_EN SHALL control one-shot mode.
REQ-029 With DECODER_SCAN_ONESHOT_EN defined, ports SHALL be added: oneshot input 1 and done output 1.
REQ-030 With the macro defined, oneshot is sampled at start; if 1, the block SHALL go IDLE instead of BLANK when code 11 expires, and pulse done=1 for exactly 1 cycle.
REQ-031 With the macro defined, stop SHALL NOT pulse done.
REQ-032 Without DECODER_SCAN_ONESHOT_EN, the oneshot and done ports SHALL be absent, and scanning SHALL be continuous until stop or rst.

Structure
REQ-033 Package decoder_scan_pkg SHALL hold the state enum (IDLE, RUN, BLANK), CODE_W=2 and CODE_LAST=2'b11.
REQ-034 The dwell counter SHALL be sub-module decoder_dwell_cnt, with ports for load, load value, decrement enable and zero flag.
REQ-035 {a,b,c} SHALL connect directly to the 2-to-4 decoder select and enable inputs; no glue logic.

Verification
REQ-036 Test: dwell=2, start pulse -> c=1 next cycle; codes 00,01,10,11,00 each held 3 cycles; one c=0 cycle between codes.
REQ-037 Test: dwell=0 -> c toggles 1,0,1,0; {a,b} steps each 2 cycles and wraps 11->00.
REQ-038 Test: stop in the 2nd RUN cycle of code 10 -> next cycle a=b=c=0, busy=0; start+stop asserted together -> stays IDLE.
REQ-039 Test: rst asserted between clock edges during RUN -> c=0 immediately; after release, outputs stay 0 until start.
REQ-040 Test: dwell changed 2->5 mid-code -> current code still held 3 cycles total; the next code is held 6 cycles.
REQ-041 Test (macro defined): oneshot=1, dwell=1 -> 4 codes, then IDLE with a single done pulse; start ignored during the scan.
